pcpu_mio_bridge: RTL and testbench
==================================

Name: pcpu_mio_bridge

Overview:
Parametrised memory/IO bus bridge between the pipelined CPU's MEM stage and the MIO bus. It accepts one load/store request at a time, runs the MIO_ready handshake, and handles byte, half and word lane steering and sign extension. It stalls the pipeline until the access completes, flags misaligned and timed-out accesses, and exports its FSM state for debug.

Parameters:
DATA_W, 32, bus data width; must be a multiple of 32 (32 or 64).
ADDR_W, 32, address width.
TIMEOUT, 255, maximum WAIT cycles before timeout_err; range 1..65535.

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  synchronous, active-low reset.
req_valid  in  1  MEM stage presents an access.
req_we  in  1  1 = store, 0 = load.
req_size  in  2  0 byte, 1 half, 2 word, 3 dword (legal only if DATA_W=64).
req_signed  in  1  sign-extend load result.
req_addr  in  ADDR_W  byte address.
req_wdata  in  DATA_W  store data, right-aligned.
stall  out  1  hold pipeline.
rsp_valid  out  1  one-cycle completion pulse.
rsp_rdata  out  DATA_W  extended load data.
misalign_err  out  1  with rsp_valid: misaligned or illegal size.
timeout_err  out  1  with rsp_valid: bus did not answer.
MIO_ready  in  1  bus completes the access.
Data_in  in  DATA_W  bus read data.
CPU_MIO  out  1  bus request.
mem_w  out  1  bus write strobe.
Addr_out  out  ADDR_W  bus address, low lane bits forced to 0.
Data_out  out  DATA_W  store data replicated to every lane.
byte_en  out  DATA_W/8  active byte lanes.
state  out  5  FSM state code.

Behaviour:
- Reset values (reset low at a clk edge): state IDLE. CPU_MIO, mem_w, rsp_valid, misalign_err and timeout_err are 0. Addr_out, Data_out, byte_en and rsp_rdata are 0. The internal counter is 0. Reset has priority over every other input, including mid-WAIT: CPU_MIO drops at that edge and no response is issued.
- State codes: IDLE=5'd0, WAIT=5'd2, DONE=5'd3, ERR=5'd4. All other codes are unused and return to IDLE.
- stall = (state==IDLE && req_valid) || state==WAIT. This is combinational, so it is high in the request cycle itself.
- IDLE, req_valid=1:
  - Aligned and legal size: latch we, size, signed and addr. Drive CPU_MIO=1, mem_w=req_we, Addr_out, Data_out and byte_en from the next edge. Go to WAIT and clear the counter.
  - Misaligned (address not a multiple of 2^size) or illegal size: go to ERR with misalign_err. No bus cycle is issued.
- WAIT:
  - CPU_MIO held at 1. The counter increments each cycle.
  - MIO_ready=1: capture Data_in. Select the lane at the latched address offset. Zero- or sign-extend it per req_signed. Go to DONE; CPU_MIO and mem_w drop at this edge.
  - MIO_ready=0 and counter==TIMEOUT-1: go to ERR with timeout_err. CPU_MIO drops.
  - MIO_ready has priority over timeout in the same cycle.
- DONE: rsp_valid=1 for one cycle, stall=0. rsp_rdata is valid for loads and 0 for stores. Next state is IDLE. The pipeline advances in this cycle, so req_valid is ignored here.
- ERR: rsp_valid=1 for one cycle with exactly one error flag set, rsp_rdata=0, stall=0. Next state is IDLE.
- Minimum load/store latency: request at cycle 0, MIO_ready at cycle 1, rsp_valid at cycle 2. A new request is accepted no earlier than the cycle after DONE/ERR.
- byte_en: size s at offset o sets bits o .. o+2^s-1.
- Data_out replication: byte stores copy the byte to all lanes; half stores copy the half to all half-lanes.

Optional Feature:
PCPU_MIO_TIMEOUT_EN
- Defined: the timeout counter and the WAIT->ERR timeout path are built.
- Not defined: WAIT waits for MIO_ready indefinitely, timeout_err is tied to 0, and no counter is built. The TIMEOUT parameter is ignored.

Test Plan:
- Word load: addr 0x100, MIO_ready high one cycle after request, Data_in 0xDEADBEEF -> CPU_MIO high 1 cycle, rsp_valid at cycle 2, rsp_rdata 0xDEADBEEF, stall high cycles 0-1.
- Signed byte load: addr 0x103, Data_in 0x80FF_0000 -> byte_en 4'b1000, rsp_rdata 0xFFFFFF80; the same load with req_signed=0 -> 0x00000080.
- Half store: addr 0x202, wdata 0x1234 -> mem_w=1, byte_en 4'b1100, Data_out 0x12341234, Addr_out 0x200, rsp_rdata 0.
- Misaligned word: addr 0x101 -> no CPU_MIO, next cycle rsp_valid=1 and misalign_err=1. req_size=3 with DATA_W=32 -> same result.
- Timeout (macro defined, TIMEOUT=4): MIO_ready held low -> ERR after 4 WAIT cycles, timeout_err=1, CPU_MIO low. Macro undefined -> stays in WAIT for 100 cycles, then completes normally when MIO_ready rises.
- Reset mid-WAIT: reset low during WAIT -> state 0 and CPU_MIO 0 at the next edge, no rsp_valid. A request issued after reset releases completes normally.

Source files
------------

// File: rtl/pcpu_mio_bridge_if.sv
// Signal bundle between the CPU MEM stage, the pcpu_mio_bridge and the MIO bus.
// The bridge connects through the slave modport; the CPU/bus environment uses master.
interface pcpu_mio_bridge_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    logic                  req_valid;
    logic                  req_we;
    logic [1:0]            req_size;
    logic                  req_signed;
    logic [ADDR_W-1:0]     req_addr;
    logic [DATA_W-1:0]     req_wdata;
    logic                  stall;
    logic                  rsp_valid;
    logic [DATA_W-1:0]     rsp_rdata;
    logic                  misalign_err;
    logic                  timeout_err;
    logic                  MIO_ready;
    logic [DATA_W-1:0]     Data_in;
    logic                  CPU_MIO;
    logic                  mem_w;
    logic [ADDR_W-1:0]     Addr_out;
    logic [DATA_W-1:0]     Data_out;
    logic [DATA_W/8-1:0]   byte_en;
    logic [4:0]            state;

    modport slave (
        input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
        input  MIO_ready, Data_in,
        output stall, rsp_valid, rsp_rdata, misalign_err, timeout_err,
        output CPU_MIO, mem_w, Addr_out, Data_out, byte_en, state
    );

    modport master (
        output req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
        output MIO_ready, Data_in,
        input  stall, rsp_valid, rsp_rdata, misalign_err, timeout_err,
        input  CPU_MIO, mem_w, Addr_out, Data_out, byte_en, state
    );
endinterface

// File: rtl/pcpu_mio_bridge.sv
// MEM-stage to MIO bus bridge: one access at a time, lane steering, sign extension, error flags.
// Optional macro PCPU_MIO_TIMEOUT_EN builds the WAIT timeout counter and timeout_err path.
module pcpu_mio_bridge #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               reset,
    pcpu_mio_bridge_if.slave   bus
);
    localparam int NB       = DATA_W / 8;
    localparam int LANE_W   = $clog2(NB);
    localparam int MAX_SIZE = LANE_W;

    if ((DATA_W != 32) && (DATA_W != 64)) begin : g_bad_data_w
        $error("pcpu_mio_bridge: DATA_W must be 32 or 64");
    end
    if ((TIMEOUT < 1) || (TIMEOUT > 65535)) begin : g_bad_timeout
        $error("pcpu_mio_bridge: TIMEOUT must be in 1..65535");
    end

    typedef enum logic [4:0] {
        S_IDLE = 5'd0,
        S_WAIT = 5'd2,
        S_DONE = 5'd3,
        S_ERR  = 5'd4
    } state_t;

    state_t              state_p1;
    logic                we_p1;
    logic [1:0]          size_p1;
    logic                sgn_p1;
    logic [LANE_W-1:0]   off_p1;
    logic                cpu_mio_p1;
    logic                mem_w_p1;
    logic [ADDR_W-1:0]   addr_out_p1;
    logic [DATA_W-1:0]   data_out_p1;
    logic [NB-1:0]       byte_en_p1;
    logic                vld_p2;
    logic [DATA_W-1:0]   rdata_p2;
    logic                misalign_p2;
`ifdef PCPU_MIO_TIMEOUT_EN
    logic [15:0]         cnt_p1;
    logic                timeout_p2;
`endif

    function automatic logic size_ok(input logic [ADDR_W-1:0] a, input logic [1:0] s);
        logic ok;
        case (s)
            2'd0:    ok = 1'b1;
            2'd1:    ok = ~a[0];
            2'd2:    ok = ~|a[1:0];
            default: ok = (MAX_SIZE == 3) && ~|a[2:0];
        endcase
        return ok;
    endfunction

    function automatic logic [NB-1:0] lane_mask(input logic [1:0] s, input logic [LANE_W-1:0] o);
        logic [NB-1:0] m;
        case (s)
            2'd0:    m = NB'(1);
            2'd1:    m = NB'(3);
            2'd2:    m = NB'(15);
            default: m = {NB{1'b1}};
        endcase
        return m << o;
    endfunction

    function automatic logic [DATA_W-1:0] replicate(input logic [1:0] s, input logic [DATA_W-1:0] w);
        logic [DATA_W-1:0] r;
        case (s)
            2'd0:    r = {NB{w[7:0]}};
            2'd1:    r = {(NB/2){w[15:0]}};
            2'd2:    r = {(DATA_W/32){w[31:0]}};
            default: r = w;
        endcase
        return r;
    endfunction

    // raw is already shifted so the addressed lane sits at bit 0
    function automatic logic [DATA_W-1:0] extend_lane(input logic [DATA_W-1:0] raw,
                                                      input logic [1:0] s, input logic sgn);
        logic signed [7:0]        b;
        logic signed [15:0]       h;
        logic signed [31:0]       w;
        logic signed [DATA_W-1:0] x;
        b = raw[7:0];
        h = raw[15:0];
        w = raw[31:0];
        case (s)
            2'd0:    x = sgn ? DATA_W'(b) : DATA_W'(raw[7:0]);
            2'd1:    x = sgn ? DATA_W'(h) : DATA_W'(raw[15:0]);
            2'd2:    x = sgn ? DATA_W'(w) : DATA_W'(raw[31:0]);
            default: x = raw;
        endcase
        return x;
    endfunction

    assign bus.stall        = ((state_p1 == S_IDLE) && bus.req_valid) || (state_p1 == S_WAIT);
    assign bus.state        = state_p1;
    assign bus.CPU_MIO      = cpu_mio_p1;
    assign bus.mem_w        = mem_w_p1;
    assign bus.Addr_out     = addr_out_p1;
    assign bus.Data_out     = data_out_p1;
    assign bus.byte_en      = byte_en_p1;
    assign bus.rsp_valid    = vld_p2;
    assign bus.rsp_rdata    = rdata_p2;
    assign bus.misalign_err = misalign_p2;
`ifdef PCPU_MIO_TIMEOUT_EN
    assign bus.timeout_err  = timeout_p2;
`else
    assign bus.timeout_err  = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_p1    <= S_IDLE;
            we_p1       <= 1'b0;
            size_p1     <= 2'd0;
            sgn_p1      <= 1'b0;
            off_p1      <= '0;
            cpu_mio_p1  <= 1'b0;
            mem_w_p1    <= 1'b0;
            addr_out_p1 <= '0;
            data_out_p1 <= '0;
            byte_en_p1  <= '0;
            vld_p2      <= 1'b0;
            rdata_p2    <= '0;
            misalign_p2 <= 1'b0;
`ifdef PCPU_MIO_TIMEOUT_EN
            cnt_p1      <= '0;
            timeout_p2  <= 1'b0;
`endif
        end else begin
            vld_p2      <= 1'b0;
            misalign_p2 <= 1'b0;
`ifdef PCPU_MIO_TIMEOUT_EN
            timeout_p2  <= 1'b0;
`endif
            case (state_p1)
                // request stage: latch the access and launch the bus cycle
                S_IDLE: begin
                    if (bus.req_valid) begin
                        if (size_ok(bus.req_addr, bus.req_size) && (int'(bus.req_size) <= MAX_SIZE)) begin
                            we_p1       <= bus.req_we;
                            size_p1     <= bus.req_size;
                            sgn_p1      <= bus.req_signed;
                            off_p1      <= bus.req_addr[LANE_W-1:0];
                            cpu_mio_p1  <= 1'b1;
                            mem_w_p1    <= bus.req_we;
                            addr_out_p1 <= {bus.req_addr[ADDR_W-1:LANE_W], {LANE_W{1'b0}}};
                            data_out_p1 <= replicate(bus.req_size, bus.req_wdata);
                            byte_en_p1  <= lane_mask(bus.req_size, bus.req_addr[LANE_W-1:0]);
`ifdef PCPU_MIO_TIMEOUT_EN
                            cnt_p1      <= '0;
`endif
                            state_p1    <= S_WAIT;
                        end else begin
                            vld_p2      <= 1'b1;
                            misalign_p2 <= 1'b1;
                            rdata_p2    <= '0;
                            state_p1    <= S_ERR;
                        end
                    end
                end
                // bus stage: wait for MIO_ready, steer and extend the read lane
                S_WAIT: begin
`ifdef PCPU_MIO_TIMEOUT_EN
                    cnt_p1 <= cnt_p1 + 16'd1;
`endif
                    if (bus.MIO_ready) begin
                        cpu_mio_p1 <= 1'b0;
                        mem_w_p1   <= 1'b0;
                        vld_p2     <= 1'b1;
                        rdata_p2   <= we_p1 ? '0
                                    : extend_lane(bus.Data_in >> {off_p1, 3'b000}, size_p1, sgn_p1);
                        state_p1   <= S_DONE;
                    end
`ifdef PCPU_MIO_TIMEOUT_EN
                    else if (cnt_p1 == 16'(TIMEOUT - 1)) begin
                        cpu_mio_p1 <= 1'b0;
                        mem_w_p1   <= 1'b0;
                        vld_p2     <= 1'b1;
                        timeout_p2 <= 1'b1;
                        rdata_p2   <= '0;
                        state_p1   <= S_ERR;
                    end
`endif
                end
                // response stage: single-cycle pulse, pipeline advances
                S_DONE, S_ERR: begin
                    rdata_p2 <= '0;
                    state_p1 <= S_IDLE;
                end
                default: state_p1 <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_pcpu_mio_bridge.sv
// Scoreboard bench for pcpu_mio_bridge (DATA_W=32); timeout expectations follow PCPU_MIO_TIMEOUT_EN.
module tb_pcpu_mio_bridge;
    localparam int TMO = 4;

    typedef struct packed {
        logic [31:0] rdata;
        logic        mis;
        logic        to;
    } rsp_t;

    logic clk;
    logic reset;
    int   checks;
    int   failures;
    rsp_t sb[$];

    pcpu_mio_bridge_if #(.DATA_W(32), .ADDR_W(32)) bus ();

    pcpu_mio_bridge #(.DATA_W(32), .ADDR_W(32), .TIMEOUT(TMO)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] m_load(input logic [31:0] d, input logic [31:0] a,
                                           input int sz, input bit sg);
        logic [31:0] r;
        int n;
        int o;
        n = 1 << sz;
        o = int'(a[1:0]);
        r = '0;
        for (int i = 0; i < n; i++) r[i*8 +: 8] = d[(o+i)*8 +: 8];
        if (sg && r[n*8-1])
            for (int i = n*8; i < 32; i++) r[i] = 1'b1;
        return r;
    endfunction

    function automatic logic [3:0] m_be(input logic [31:0] a, input int sz);
        logic [3:0] be;
        be = '0;
        for (int i = 0; i < (1 << sz); i++) be[int'(a[1:0]) + i] = 1'b1;
        return be;
    endfunction

    function automatic logic [31:0] m_dout(input logic [31:0] w, input int sz);
        logic [31:0] r;
        int n;
        n = 1 << sz;
        for (int i = 0; i < 4; i++) r[i*8 +: 8] = w[(i % n)*8 +: 8];
        return r;
    endfunction

    always @(negedge clk) begin
        rsp_t e;
        if (bus.rsp_valid === 1'b1) begin
            if (sb.size() == 0) begin
                check_eq("unexpected_rsp", bus.rsp_valid, 0);
            end else begin
                e = sb.pop_front();
                check_eq("rsp_rdata", bus.rsp_rdata, e.rdata);
                check_eq("misalign_err", bus.misalign_err, e.mis);
                check_eq("timeout_err", bus.timeout_err, e.to);
            end
        end else begin
            check_eq("idle_err_flags", {bus.misalign_err, bus.timeout_err}, 0);
        end
    end

    task automatic access(input bit we, input logic [1:0] sz, input bit sg, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [31:0] din, input int delay);
        rsp_t e;
        bit   legal;
        bit   to;
        legal = (sz != 2'd3) && ((addr & ((32'd1 << sz) - 32'd1)) == 32'd0);
        to = 1'b0;
`ifdef PCPU_MIO_TIMEOUT_EN
        to = legal && (delay >= TMO);
`endif
        e.rdata = (legal && !to && !we) ? m_load(din, addr, int'(sz), sg) : 32'd0;
        e.mis   = !legal;
        e.to    = to;
        sb.push_back(e);

        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_size   = sz;
        bus.req_signed = sg;
        bus.req_addr   = addr;
        bus.req_wdata  = wd;
        #1 check_eq("stall_req", bus.stall, 1);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        if (!legal) begin
            check_eq("err_state", bus.state, 4);
            check_eq("err_no_mio", bus.CPU_MIO, 0);
            check_eq("err_stall", bus.stall, 0);
        end else begin
            check_eq("wait_state", bus.state, 2);
            check_eq("cpu_mio", bus.CPU_MIO, 1);
            check_eq("mem_w", bus.mem_w, we);
            check_eq("addr_out", bus.Addr_out, addr & 32'hFFFF_FFFC);
            check_eq("byte_en", bus.byte_en, m_be(addr, int'(sz)));
            if (we) check_eq("data_out", bus.Data_out, m_dout(wd, int'(sz)));
            check_eq("stall_wait", bus.stall, 1);
            bus.MIO_ready = 1'b0;
            for (int c = 0; c < delay; c++) begin
                @(posedge clk); #1;
                if (to && c == TMO - 1) break;
            end
            if (to) begin
                check_eq("to_state", bus.state, 4);
                check_eq("to_no_mio", bus.CPU_MIO, 0);
            end else begin
                check_eq("still_waiting", bus.state, 2);
                bus.MIO_ready = 1'b1;
                bus.Data_in   = din;
                @(posedge clk); #1;
                bus.MIO_ready = 1'b0;
                bus.Data_in   = $urandom;
                check_eq("done_state", bus.state, 3);
                check_eq("done_mio", bus.CPU_MIO, 0);
                check_eq("done_mem_w", bus.mem_w, 0);
                check_eq("done_stall", bus.stall, 0);
            end
        end
        @(posedge clk); #1;
        check_eq("back_idle", bus.state, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0;
        failures = 0;
        reset = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_we = 1'b0;
        bus.req_size = 2'd0;
        bus.req_signed = 1'b0;
        bus.req_addr = '0;
        bus.req_wdata = '0;
        bus.MIO_ready = 1'b0;
        bus.Data_in = '0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_state", bus.state, 0);
        check_eq("rst_cpu_mio", bus.CPU_MIO, 0);
        check_eq("rst_mem_w", bus.mem_w, 0);
        check_eq("rst_rsp_valid", bus.rsp_valid, 0);
        check_eq("rst_addr_out", bus.Addr_out, 0);
        check_eq("rst_data_out", bus.Data_out, 0);
        check_eq("rst_byte_en", bus.byte_en, 0);
        check_eq("rst_rdata", bus.rsp_rdata, 0);
        check_eq("rst_stall", bus.stall, 0);
        reset = 1'b1;
        @(posedge clk); #1;

        access(1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 0);
        access(1'b0, 2'd0, 1'b1, 32'h103, 32'h0, 32'h80FF_0000, 0);
        access(1'b0, 2'd0, 1'b0, 32'h103, 32'h0, 32'h80FF_0000, 1);
        access(1'b1, 2'd1, 1'b0, 32'h202, 32'h1234, 32'h5555_5555, 0);
        access(1'b0, 2'd2, 1'b0, 32'h101, 32'h0, 32'h0, 0);
        access(1'b0, 2'd3, 1'b0, 32'h100, 32'h0, 32'h0, 0);
        access(1'b0, 2'd1, 1'b1, 32'h102, 32'h0, 32'h8001_0000, 0);
        access(1'b1, 2'd0, 1'b0, 32'h101, 32'hA5, 32'h0, 2);
        access(1'b1, 2'd2, 1'b0, 32'h104, 32'hCAFE_F00D, 32'h0, 3);
        access(1'b0, 2'd2, 1'b0, 32'h108, 32'h0, 32'h0BAD_F00D, 100);

        // reset in the middle of a bus cycle: no response may follow
        bus.req_valid  = 1'b1;
        bus.req_we     = 1'b0;
        bus.req_size   = 2'd2;
        bus.req_signed = 1'b0;
        bus.req_addr   = 32'h300;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        check_eq("pre_rst_wait", bus.state, 2);
        @(posedge clk); #1;
        reset = 1'b0;
        bus.MIO_ready = 1'b1;
        @(posedge clk); #1;
        bus.MIO_ready = 1'b0;
        check_eq("mid_rst_state", bus.state, 0);
        check_eq("mid_rst_cpu_mio", bus.CPU_MIO, 0);
        check_eq("mid_rst_rsp", bus.rsp_valid, 0);
        reset = 1'b1;
        @(posedge clk); #1;
        access(1'b0, 2'd2, 1'b1, 32'h10C, 32'h0, 32'h1357_9BDF, 1);

        for (int k = 0; k < 16; k++) begin
            logic [31:0] a;
            a = ($urandom & 32'h0000_FFF8) | 32'($urandom_range(0, 3));
            access(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   a, $urandom, $urandom, $urandom_range(0, 3));
        end

        repeat (3) @(posedge clk);
        #1;
        check_eq("sb_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
